// File: rtl/edge_event_encoder_16bit.sv
// Edge event encoder for a 16-bit synchronized input vector.
// Detects rising/falling edges against the previous sample, queues them in
// per-bit pending registers and emits them one byte at a time through a
// valid/ready handshake, lowest bit index first, rise before fall.
module edge_event_encoder_16bit #(
    parameter int RISE_EN = 1,
    parameter int FALL_EN = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        e,
    input  logic [15:0] d,
    input  logic        out_ready,
    input  logic        overrun_clr,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic [15:0] pending_rise,
    output logic [15:0] pending_fall,
    output logic        overrun
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam logic [15:0] RISE_MASK = (RISE_EN != 0) ? 16'hFFFF : 16'h0000;
    localparam logic [15:0] FALL_MASK = (FALL_EN != 0) ? 16'hFFFF : 16'h0000;

    state_t      state;
    logic [15:0] prev;
    logic        primed;

    logic [15:0] rise_det;
    logic [15:0] fall_det;
    logic        sel_found;
    logic [3:0]  sel_idx;
    logic        sel_rise;
    logic        take_event;
    logic [15:0] rise_clr;
    logic [15:0] fall_clr;
    logic        overrun_set;

    // Edge detection is suppressed until prev holds a real sample.
    always_comb begin
        rise_det = 16'h0000;
        fall_det = 16'h0000;
        if (e && primed) begin
            rise_det = d & ~prev & RISE_MASK;
            fall_det = ~d & prev & FALL_MASK;
        end
    end

    // Priority pick: scanning downward lets the lowest pending index win.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 4'd0;
        sel_rise  = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (pending_rise[i] || pending_fall[i]) begin
                sel_found = 1'b1;
                sel_idx   = 4'(i);
                sel_rise  = pending_rise[i];
            end
        end
    end

    // Clear masks for the event being taken; a same-cycle new edge still sets the bit.
    always_comb begin
        take_event  = (state == IDLE) && sel_found;
        rise_clr    = 16'h0000;
        fall_clr    = 16'h0000;
        if (take_event) begin
            if (sel_rise) begin
                rise_clr = 16'h0001 << sel_idx;
            end else begin
                fall_clr = 16'h0001 << sel_idx;
            end
        end
        overrun_set = (|(rise_det & pending_rise & ~rise_clr)) ||
                      (|(fall_det & pending_fall & ~fall_clr));
    end

    // Previous-sample register and primed flag follow the upstream enable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev   <= 16'h0000;
            primed <= 1'b0;
        end else if (e) begin
            prev   <= d;
            primed <= 1'b1;
        end
    end

    // Pending registers: clear the taken event, then OR in new edges so set wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_rise <= 16'h0000;
            pending_fall <= 16'h0000;
        end else begin
            pending_rise <= (pending_rise & ~rise_clr) | rise_det;
            pending_fall <= (pending_fall & ~fall_clr) | fall_det;
        end
    end

    // Sticky overrun flag; a lost edge in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun <= 1'b0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // Output FSM: load an event byte in IDLE, hold it in PRESENT until accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        out_data  <= {sel_rise, 3'b000, sel_idx};
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_event_encoder_16bit.sv
// Self-checking bench for edge_event_encoder_16bit: a per-cycle vector table,
// hand-written multi-cycle sequences, and an event scoreboard queue that is
// checked at every valid/ready handshake.
module tb_edge_event_encoder_16bit;

    logic        clk;
    logic        resetn;
    logic        e;
    logic [15:0] d;
    logic        out_ready;
    logic        overrun_clr;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [15:0] pending_rise;
    logic [15:0] pending_fall;
    logic        overrun;

    int total;
    int bad;
    logic [7:0] sb[$];

    typedef struct {
        logic        e;
        logic [15:0] d;
        logic        ready;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [15:0] exp_pr;
        logic [15:0] exp_pf;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs[6];

    edge_event_encoder_16bit #(.RISE_EN(1), .FALL_EN(1)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .e           (e),
        .d           (d),
        .out_ready   (out_ready),
        .overrun_clr (overrun_clr),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .pending_rise(pending_rise),
        .pending_fall(pending_fall),
        .overrun     (overrun)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void checkOutput(input string name, input logic [31:0] act,
                                        input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Inputs are stable at the falling edge, so a handshake seen here completes on the next rise.
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_event: got 0x%0h expected none at %0t", out_data, $time);
            end else begin
                checkOutput("event", {24'h0, out_data}, {24'h0, sb.pop_front()});
            end
        end
    end

    task automatic applyStimulus(input logic ie, input logic [15:0] id, input logic ir,
                                 input logic ic);
        e           = ie;
        d           = id;
        out_ready   = ir;
        overrun_clr = ic;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        resetn      = 1'b0;
        e           = 1'b0;
        d           = 16'h0000;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("rst_data", {24'h0, out_data}, 32'h0);
        checkOutput("rst_pr", {16'h0, pending_rise}, 32'h0);
        checkOutput("rst_pf", {16'h0, pending_fall}, 32'h0);
        checkOutput("rst_ovr", {31'h0, overrun}, 32'h0);
        resetn = 1'b1;
    endtask

    // Hold ready high until every expected event has been accepted, then idle a few cycles.
    task automatic drainEvents(input int limit);
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain_queue_empty", sb.size(), 32'h0);
        checkOutput("drain_idle", {31'h0, out_valid}, 32'h0);
        out_ready = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        resetn      = 1'b0;
        e           = 1'b0;
        d           = 16'h0000;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;

        // Prime on 0000, rise on bits 0 and 2, ready held high.
        vecs[0] = '{1'b1, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 16'h0005, 1'b1, 1'b0, 8'h00, 16'h0005, 16'h0000, 1'b0};
        vecs[2] = '{1'b1, 16'h0005, 1'b1, 1'b1, 8'h80, 16'h0004, 16'h0000, 1'b0};
        vecs[3] = '{1'b1, 16'h0005, 1'b1, 1'b0, 8'h00, 16'h0004, 16'h0000, 1'b0};
        vecs[4] = '{1'b1, 16'h0005, 1'b1, 1'b1, 8'h82, 16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{1'b1, 16'h0005, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0};

        doReset();
        sb.push_back(8'h80);
        sb.push_back(8'h82);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].e, vecs[i].d, vecs[i].ready, 1'b0);
            checkOutput($sformatf("vec%0d_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d_data", i), {24'h0, out_data}, {24'h0, vecs[i].exp_data});
            end
            checkOutput($sformatf("vec%0d_pr", i), {16'h0, pending_rise}, {16'h0, vecs[i].exp_pr});
            checkOutput($sformatf("vec%0d_pf", i), {16'h0, pending_fall}, {16'h0, vecs[i].exp_pf});
            checkOutput($sformatf("vec%0d_ovr", i), {31'h0, overrun}, {31'h0, vecs[i].exp_ovr});
        end
        checkOutput("vec_queue_empty", sb.size(), 32'h0);

        // First enabled cycle only primes, even with all ones.
        doReset();
        applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
        checkOutput("prime_pr", {16'h0, pending_rise}, 32'h0);
        checkOutput("prime_pf", {16'h0, pending_fall}, 32'h0);
        applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
        checkOutput("prime_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("prime_pr2", {16'h0, pending_rise}, 32'h0);
        drainEvents(10);

        // Held output while ready is low, remaining fall queued behind it.
        doReset();
        sb.push_back(8'h00);
        sb.push_back(8'h0F);
        applyStimulus(1'b1, 16'h8001, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
        checkOutput("hold_pf_initial", {16'h0, pending_fall}, 32'h8001);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
            checkOutput($sformatf("hold%0d_valid", i), {31'h0, out_valid}, 32'h1);
            checkOutput($sformatf("hold%0d_data", i), {24'h0, out_data}, 32'h00);
            checkOutput($sformatf("hold%0d_pf", i), {16'h0, pending_fall}, 32'h8000);
        end
        drainEvents(20);
        checkOutput("hold_pf_end", {16'h0, pending_fall}, 32'h0);

        // Bit 3 toggles while bit 0 event is stalled: overrun, set-wins-over-clear for the flag.
        doReset();
        sb.push_back(8'h80);
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0009, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
        checkOutput("tog_no_ovr_yet", {31'h0, overrun}, 32'h0);
        applyStimulus(1'b1, 16'h0009, 1'b0, 1'b0);
        checkOutput("tog_ovr", {31'h0, overrun}, 32'h1);
        checkOutput("tog_pr", {16'h0, pending_rise}, 32'h0008);
        checkOutput("tog_pf", {16'h0, pending_fall}, 32'h0008);
        checkOutput("tog_data_stable", {24'h0, out_data}, 32'h80);
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b1);
        checkOutput("tog_ovr_set_wins", {31'h0, overrun}, 32'h1);
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b1);
        checkOutput("tog_ovr_cleared", {31'h0, overrun}, 32'h0);
        overrun_clr = 1'b0;
        sb.push_back(8'h83);
        sb.push_back(8'h03);
        drainEvents(20);
        checkOutput("tog_pr_end", {16'h0, pending_rise}, 32'h0);
        checkOutput("tog_pf_end", {16'h0, pending_fall}, 32'h0);

        // New rise on bit 3 in the same cycle its pending bit is taken.
        doReset();
        sb.push_back(8'h80);
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0009, 1'b0, 1'b0);
        checkOutput("coin_pr_before", {16'h0, pending_rise}, 32'h0008);
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0001, 1'b1, 1'b0);
        checkOutput("coin_idle", {31'h0, out_valid}, 32'h0);
        applyStimulus(1'b1, 16'h0009, 1'b0, 1'b0);
        checkOutput("coin_valid", {31'h0, out_valid}, 32'h1);
        checkOutput("coin_data", {24'h0, out_data}, 32'h83);
        checkOutput("coin_pr_kept", {16'h0, pending_rise}, 32'h0008);
        checkOutput("coin_pf", {16'h0, pending_fall}, 32'h0008);
        checkOutput("coin_no_ovr", {31'h0, overrun}, 32'h0);
        sb.push_back(8'h83);
        sb.push_back(8'h83);
        sb.push_back(8'h03);
        drainEvents(20);

        // Changes while e=0 are invisible until e returns high.
        doReset();
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 16'h00FF, 1'b0, 1'b0);
            checkOutput($sformatf("gate%0d_pr", i), {16'h0, pending_rise}, 32'h0);
            checkOutput($sformatf("gate%0d_valid", i), {31'h0, out_valid}, 32'h0);
        end
        applyStimulus(1'b1, 16'h00FF, 1'b0, 1'b0);
        checkOutput("gate_pr", {16'h0, pending_rise}, 32'h00FF);
        for (int i = 0; i < 8; i++) begin
            sb.push_back(8'h80 | 8'(i));
        end
        drainEvents(40);
        checkOutput("gate_pr_end", {16'h0, pending_rise}, 32'h0);

        // Asynchronous reset while presenting discards everything at once.
        doReset();
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0011, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0011, 1'b0, 1'b0);
        checkOutput("ar_valid_before", {31'h0, out_valid}, 32'h1);
        checkOutput("ar_pr_before", {16'h0, pending_rise}, 32'h0010);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("ar_valid_now", {31'h0, out_valid}, 32'h0);
        checkOutput("ar_pr_now", {16'h0, pending_rise}, 32'h0);
        checkOutput("ar_data_now", {24'h0, out_data}, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        applyStimulus(1'b1, 16'h0011, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0011, 1'b0, 1'b0);
        checkOutput("ar_no_stale_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("ar_no_stale_pr", {16'h0, pending_rise}, 32'h0);
        drainEvents(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edge_event_encoder_16bit.md
EDGE_EVENT_ENCODER_16BIT -- requirements
Module: edge_event_encoder_16bit

Interface
REQ-001 The module SHALL have parameter RISE_EN, default 1, which when 1 enables capture of rising (0->1) edges.
REQ-002 The module SHALL have parameter FALL_EN, default 1, which when 1 enables capture of falling (1->0) edges.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 e  input  1  sample enable, the same enable that drives the upstream 16-bit two-stage register.
REQ-006 d  input  16  synchronized input vector from the upstream two-stage register output.
REQ-007 out_ready  input  1  consumer ready for an event byte.
REQ-008 overrun_clr  input  1  clears the overrun flag.
REQ-009 out_valid  output  1  event byte available.
REQ-010 out_data  output  8  event byte: [7] 1 = rising, 0 = falling; [6:4] = 000; [3:0] = bit index.
REQ-011 pending_rise  output  16  rising events not yet emitted.
REQ-012 pending_fall  output  16  falling events not yet emitted.
REQ-013 overrun  output  1  sticky flag: an edge was lost.

Function
REQ-014 prev[15:0] SHALL load d on every cycle with e=1 and SHALL hold when e=0.
REQ-015 A primed flag SHALL be set on the first e=1 cycle after reset; no edges SHALL be detected on that cycle.
REQ-016 When e=1 and primed=1: rise = d & ~prev, masked by RISE_EN; fall = ~d & prev, masked by FALL_EN. When e=0, no edges SHALL be detected.
REQ-017 Each detected edge SHALL set its bit in pending_rise or pending_fall on the same clock edge.
REQ-018 If the edge's pending bit is already 1 and is not cleared in that cycle, overrun SHALL be set and the pending bit SHALL stay 1, so one event is represented.
REQ-019 overrun SHALL clear on overrun_clr=1; if a set and a clear occur in the same cycle, set SHALL win.
REQ-020 The FSM SHALL have two states, IDLE and PRESENT.
REQ-021 IDLE with any pending bit set: the FSM SHALL select the lowest index i with pending_rise[i] or pending_fall[i]; it SHALL choose rise over fall at equal index, load out_data, clear that pending bit, and go to PRESENT.
REQ-022 PRESENT: out_valid SHALL be 1; out_data SHALL hold stable until out_valid and out_ready are both 1.
REQ-023 On that handshake the FSM SHALL return to IDLE. Maximum throughput SHALL be one event per 2 cycles.
REQ-024 IDLE with no pending bits: out_valid SHALL be 0 and the FSM SHALL remain in IDLE.
REQ-025 If a new edge on bit i coincides with clearing bit i of the same type, set SHALL win: the bit stays pending and a second event is emitted later, with no overrun.
REQ-026 The selected event SHALL not be re-emitted unless a new edge re-sets its bit.
REQ-027 out_ready while out_valid=0 SHALL have no effect.
REQ-028 Edges detected while in PRESENT SHALL accumulate in the pending registers without disturbing out_data.

Reset
REQ-029 While resetn=0: prev, pending_rise, pending_fall, out_data = 0; out_valid, overrun, primed = 0; FSM = IDLE.
REQ-030 Assertion of resetn SHALL take effect immediately, including in PRESENT; the in-flight event SHALL be discarded and out_valid SHALL drop without waiting for clk.
REQ-031 After release, the first e=1 cycle SHALL only prime prev (per REQ-015).

Verification
REQ-032 Scenario: reset, e=1, d=0000, then d=0005, out_ready=1. Required: out_data=0x80 and then 0x82, in order; pending ends at 0.
REQ-033 Scenario: primed with d=8001, then d=0000, out_ready=0 for 10 cycles. Required: out_valid=1 and out_data=0x00 stable throughout; pending_fall=8000; then 0x0F after ready.
REQ-034 Scenario: bit 3 toggles 0->1->0->1 with e=1 while out_ready=0. Required: overrun=1; pending_rise[3]=1 and pending_fall[3]=1; events 0x83 and then 0x03 after ready.
REQ-035 Scenario: first e=1 cycle after reset with d=FFFF. Required: no events and no pending bits set.
REQ-036 Scenario: e=0 while d changes from 0000 to 00FF, then e=1. Required: rising events appear only after e=1, indices 0-7, in ascending order.
REQ-037 Scenario: resetn pulsed low while out_valid=1 with pending_rise=0010. Required: out_valid=0 and pending=0 immediately; no stale event after release.
